serial_subtractor_14bit: RTL and testbench



---
 rtl/calc_pkg.sv | 18 +
 rtl/full_subtractor_1bit.sv | 13 +
 rtl/serial_subtractor_14bit.sv | 97 +++++++++
 tb/tb_serial_subtractor_14bit.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared types and sizing helpers for the calculator arithmetic blocks.
package calc_pkg;

  localparam int WIDTH_DEFAULT = 14;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } sub_state_t;

  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  localparam int CNT_W = cnt_width(WIDTH_DEFAULT);

endpackage

// File: rtl/full_subtractor_1bit.sv
// Single-bit full subtractor cell: d = a - b - bin, with borrow out.
module full_subtractor_1bit (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor_14bit.sv
// Bit-serial subtractor: computes a - b - bin LSB first, one bit per clock,
// returning a WIDTH+1 bit two's-complement difference and borrow-out.
module serial_subtractor_14bit
  import calc_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   diff,
  output logic             bout
);

  localparam int CW = cnt_width(WIDTH);

  sub_state_t       r_state;
  sub_state_t       w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-2:0] r_res;
  logic             r_borrow;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH:0]   r_diff;
  logic             w_d;
  logic             w_bo;
  logic             w_accept;
  logic             w_last;

  full_subtractor_1bit u_fs (
    .a    (r_a[0]),
    .b    (r_b[0]),
    .bin  (r_borrow),
    .d    (w_d),
    .bout (w_bo)
  );

  // A new request is taken in IDLE and also in DONE, so back-to-back ops have no gap.
  assign w_accept = start && (r_state != BUSY);
  assign w_last   = (r_state == BUSY) && (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = BUSY;
      BUSY:    if (w_last) w_next = DONE;
      DONE:    w_next = start ? BUSY : IDLE;
      default: w_next = IDLE;
    endcase
  end

  // The final bit and borrow go straight into diff on the last edge, so diff
  // only ever changes as DONE begins and never exposes a partial result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_res    <= '0;
      r_borrow <= 1'b0;
      r_cnt    <= '0;
      r_diff   <= '0;
    end else if (w_accept) begin
      r_a      <= a;
      r_b      <= b;
      r_borrow <= bin;
      r_cnt    <= '0;
    end else if (r_state == BUSY) begin
      r_a      <= r_a >> 1;
      r_b      <= r_b >> 1;
      r_res    <= {w_d, r_res[WIDTH-2:1]};
      r_borrow <= w_bo;
      r_cnt    <= r_cnt + CW'(1);
      if (w_last) begin
        r_diff <= {w_bo, w_d, r_res};
      end
    end
  end

  assign busy = (r_state == BUSY);
  assign done = (r_state == DONE);
  assign diff = r_diff;
  assign bout = r_diff[WIDTH];

endmodule

// File: tb/tb_serial_subtractor_14bit.sv
// Directed self-checking bench for serial_subtractor_14bit.
module tb_serial_subtractor_14bit;

  localparam int W   = 14;
  localparam int LAT = 15;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [W:0]   diff;
  logic         bout;

  int checks = 0;
  int errors = 0;

  serial_subtractor_14bit #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issues one start pulse and counts rising edges, the accepting edge being
  // edge 1, until done is seen 1 ns after an edge (bounded to 40 edges).
  task automatic do_op(input logic [W-1:0] va, input logic [W-1:0] vb,
                       input logic vbin, output int edges);
    @(negedge clk);
    a = va; b = vb; bin = vbin; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    edges = 1;
    while (!done && edges < 40) begin
      @(posedge clk); #1;
      edges++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || diff !== 15'd0 || bout !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_state: busy=%b done=%b diff=%h bout=%b, need 0 0 0000 0",
               busy, done, diff, bout);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_vectors();
    logic [W-1:0] va [4] = '{14'h2AAA, 14'h1555, 14'h0000, 14'h3FFF};
    logic [W-1:0] vb [4] = '{14'h1555, 14'h2AAA, 14'h0000, 14'h0000};
    logic         vc [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [W:0]   ex [4] = '{15'h1555, 15'h6AAB, 15'h7FFF, 15'h3FFF};
    logic         eb [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    int edges;
    for (int i = 0; i < 4; i++) begin
      do_op(va[i], vb[i], vc[i], edges);
      checks++;
      if (edges !== LAT) begin
        errors++;
        $display("[TB] FAIL latency_%0d: done after %0d edges, need %0d", i, edges, LAT);
      end
      checks++;
      if (diff !== ex[i] || bout !== eb[i]) begin
        errors++;
        $display("[TB] FAIL diff_%0d: diff=%h bout=%b, need %h %b", i, diff, bout, ex[i], eb[i]);
      end
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || diff !== ex[i]) begin
        errors++;
        $display("[TB] FAIL after_done_%0d: done=%b busy=%b diff=%h, need 0 0 %h",
                 i, done, busy, diff, ex[i]);
      end
    end
  endtask

  task automatic test_reset_mid_busy();
    int edges;
    @(negedge clk);
    a = 14'h0100; b = 14'h0001; bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || diff !== 15'd0 || bout !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_mid_busy: busy=%b done=%b diff=%h bout=%b, need 0 0 0000 0",
               busy, done, diff, bout);
    end
    @(negedge clk); rst_n = 1'b1;
    do_op(14'h2AAA, 14'h1555, 1'b0, edges);
    checks++;
    if (edges !== LAT || diff !== 15'h1555 || bout !== 1'b0) begin
      errors++;
      $display("[TB] FAIL op_after_reset: edges=%0d diff=%h bout=%b, need %0d 1555 0",
               edges, diff, bout, LAT);
    end
  endtask

  task automatic test_start_held();
    int edges;
    int pulses;
    int done_edge;
    @(negedge clk);
    a = 14'd3000; b = 14'd1000; bin = 1'b0; start = 1'b1;
    pulses = 0; done_edge = 0;
    for (int e = 1; e <= 24; e++) begin
      @(posedge clk); #1;
      if (done) begin
        pulses++;
        if (done_edge == 0) done_edge = e;
      end
      if (e < 10) begin
        a = 14'(e * 77); b = 14'(e * 1301); bin = e[0];
      end else begin
        start = 1'b0;
      end
      if (e == LAT) edges = e;
    end
    checks++;
    if (pulses !== 1 || done_edge !== LAT) begin
      errors++;
      $display("[TB] FAIL start_held_pulses: pulses=%0d at edge %0d, need 1 at %0d",
               pulses, done_edge, LAT);
    end
    checks++;
    if (diff !== 15'd2000 || bout !== 1'b0) begin
      errors++;
      $display("[TB] FAIL start_held_diff: diff=%0d bout=%b, need 2000 0", diff, bout);
    end
  endtask

  task automatic test_back_to_back();
    int edges;
    int held_bad;
    do_op(14'd50, 14'd60, 1'b0, edges);
    checks++;
    if (edges !== LAT || diff !== 15'h7FF6 || bout !== 1'b1) begin
      errors++;
      $display("[TB] FAIL b2b_first: edges=%0d diff=%h bout=%b, need %0d 7ff6 1",
               edges, diff, bout, LAT);
    end
    a = 14'd100; b = 14'd1; bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_no_gap: busy=%b done=%b, need 1 0", busy, done);
    end
    edges = 1; held_bad = 0;
    while (!done && edges < 40) begin
      if (diff !== 15'h7FF6) held_bad++;
      @(posedge clk); #1;
      edges++;
    end
    checks++;
    if (held_bad !== 0) begin
      errors++;
      $display("[TB] FAIL b2b_hold: diff changed early in %0d samples, need 0", held_bad);
    end
    checks++;
    if (edges !== LAT || diff !== 15'd99 || bout !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_second: edges=%0d diff=%0d bout=%b, need %0d 99 0",
               edges, diff, bout, LAT);
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_reset_mid_busy();
    test_start_held();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
